// File: rtl/fcl_loss_grad.sv
// MSE-gradient stage after the fully connected layer: streams one element per cycle to build
// (output - one_hot(label)), tracks argmax and counts correct predictions. Macro FCL_LOSS_SAT_EN selects saturating errors.
module fcl_loss_grad #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 8,
  parameter int OUTPUT_DIM = 10,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WIDTH-1:0]           fcl_output [OUTPUT_DIM],
  input  logic [$clog2(OUTPUT_DIM):0]       label,
  output logic                              err_valid,
  input  logic                              err_ready,
  output logic signed [WIDTH-1:0]           output_error [OUTPUT_DIM],
  output logic [$clog2(OUTPUT_DIM)-1:0]     pred_class,
  output logic                              pred_correct,
  output logic [CNT_W-1:0]                  correct_count
);

  localparam int IDX_W = $clog2(OUTPUT_DIM);
  localparam int LBL_W = IDX_W + 1;
  localparam logic signed [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(OUTPUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] x_reg   [OUTPUT_DIM];
  logic signed [WIDTH-1:0] err_buf [OUTPUT_DIM];
  logic [LBL_W-1:0]        label_reg;
  logic [IDX_W-1:0]        idx;
  logic signed [WIDTH-1:0] max_val;
  logic [IDX_W-1:0]        max_idx;

  logic signed [WIDTH-1:0] cur_x;
  logic signed [WIDTH:0]   target;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] err_elem;
  logic                    is_max;
  logic                    last_idx;
  logic [IDX_W-1:0]        new_max_idx;
  logic                    new_correct;

  // Single shared subtractor/comparator operating on the element selected by idx
  always_comb begin
    cur_x       = x_reg[idx];
    target      = ({1'b0, idx} == label_reg) ? ONE : '0;
    diff        = {cur_x[WIDTH-1], cur_x} - target;
    err_elem    = diff[WIDTH-1:0];
`ifdef FCL_LOSS_SAT_EN
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      err_elem = diff[WIDTH] ? MIN_VAL : MAX_VAL;
    end
`endif
    is_max      = (cur_x > max_val);
    last_idx    = (idx == LAST_IDX);
    new_max_idx = is_max ? idx : max_idx;
    new_correct = ({1'b0, new_max_idx} == label_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      err_valid     <= 1'b0;
      pred_class    <= '0;
      pred_correct  <= 1'b0;
      correct_count <= '0;
      label_reg     <= '0;
      idx           <= '0;
      max_val       <= MIN_VAL;
      max_idx       <= '0;
      for (int k = 0; k < OUTPUT_DIM; k++) begin
        output_error[k] <= '0;
        x_reg[k]        <= '0;
        err_buf[k]      <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < OUTPUT_DIM; k++) begin
              x_reg[k] <= fcl_output[k];
            end
            label_reg <= label;
            idx       <= '0;
            max_val   <= MIN_VAL;
            max_idx   <= '0;
            in_ready  <= 1'b0;
            state     <= SCAN;
          end
        end

        SCAN: begin
          err_buf[idx] <= err_elem;
          if (is_max) begin
            max_val <= cur_x;
            max_idx <= idx;
          end
          idx <= idx + 1'b1;
          // The last element bypasses err_buf so all outputs update together
          if (last_idx) begin
            for (int k = 0; k < OUTPUT_DIM - 1; k++) begin
              output_error[k] <= err_buf[k];
            end
            output_error[OUTPUT_DIM-1] <= err_elem;
            pred_class   <= new_max_idx;
            pred_correct <= new_correct;
            err_valid    <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          if (err_ready) begin
            if (pred_correct && (correct_count != CNT_MAX)) begin
              correct_count <= correct_count + 1'b1;
            end
            err_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          err_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_loss_grad.sv
// Scoreboard bench for fcl_loss_grad: expected vectors are queued on accept and compared on err_valid.
// Expected error reduction follows FCL_LOSS_SAT_EN when defined.
module tb_fcl_loss_grad;

  localparam int WIDTH      = 16;
  localparam int FRAC_BITS  = 8;
  localparam int OUTPUT_DIM = 10;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = 4;
  localparam int LBL_W      = 5;
  localparam int LATENCY    = OUTPUT_DIM;
  localparam int PERIOD     = OUTPUT_DIM + 2;

  typedef struct packed {
    logic [OUTPUT_DIM*WIDTH-1:0] err;
    logic [IDX_W-1:0]            cls;
    logic                        correct;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] fcl_output [OUTPUT_DIM];
  logic [LBL_W-1:0]        label;
  logic                    err_valid;
  logic                    err_ready;
  logic signed [WIDTH-1:0] output_error [OUTPUT_DIM];
  logic [IDX_W-1:0]        pred_class;
  logic                    pred_correct;
  logic [CNT_W-1:0]        correct_count;

  logic signed [WIDTH-1:0] stim_x [OUTPUT_DIM];
  exp_t                    exp_q [$];
  int                      checks = 0;
  int                      errors = 0;
  int                      cycle = 0;
  int                      last_accept = 0;
  logic [CNT_W-1:0]        exp_count = '0;

  fcl_loss_grad #(
    .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .OUTPUT_DIM(OUTPUT_DIM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fcl_output(fcl_output), .label(label), .err_valid(err_valid), .err_ready(err_ready),
    .output_error(output_error), .pred_class(pred_class), .pred_correct(pred_correct),
    .correct_count(correct_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: subtract one-hot target, reduce to WIDTH bits, first strict maximum wins
  function automatic exp_t model(input logic [LBL_W-1:0] lbl);
    exp_t e;
    int   v;
    int   best;
    e    = '0;
    best = 0;
    for (int k = 0; k < OUTPUT_DIM; k++) begin
      v = int'(stim_x[k]) - ((int'(lbl) == k) ? (1 << FRAC_BITS) : 0);
`ifdef FCL_LOSS_SAT_EN
      if (v > (1 << (WIDTH-1)) - 1) v = (1 << (WIDTH-1)) - 1;
      if (v < -(1 << (WIDTH-1))) v = -(1 << (WIDTH-1));
`endif
      e.err[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
      if (stim_x[k] > stim_x[best]) best = k;
    end
    e.cls     = best[IDX_W-1:0];
    e.correct = (int'(lbl) == best);
    return e;
  endfunction

  task automatic applyStimulus(input logic [LBL_W-1:0] lbl);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_ready_wait: in_ready=%b, required 1", in_ready);
    end
    for (int k = 0; k < OUTPUT_DIM; k++) fcl_output[k] = stim_x[k];
    label    = lbl;
    in_valid = 1'b1;
    exp_q.push_back(model(lbl));
    tick();
    last_accept = cycle;
    in_valid    = 1'b0;
  endtask

  task automatic checkOutput(input int hold);
    exp_t                    e;
    int                      n;
    logic signed [WIDTH-1:0] held [OUTPUT_DIM];
    logic [IDX_W-1:0]        held_cls;
    logic                    held_ok;
    int                      diffs;
    n = 0;
    while (!err_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != LATENCY) begin
      errors++;
      $display("[TB] FAIL latency: %0d cycles after accept, required %0d", n, LATENCY);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: result with empty queue, required 1 pending");
      return;
    end
    e = exp_q.pop_front();
    if (!err_valid) return;
    for (int k = 0; k < OUTPUT_DIM; k++) begin
      checks++;
      if (output_error[k] !== $signed(e.err[k*WIDTH +: WIDTH])) begin
        errors++;
        $display("[TB] FAIL err[%0d]: got %0d, required %0d", k, output_error[k],
                 $signed(e.err[k*WIDTH +: WIDTH]));
      end
    end
    checks++;
    if (pred_class !== e.cls) begin
      errors++;
      $display("[TB] FAIL pred_class: got %0d, required %0d", pred_class, e.cls);
    end
    checks++;
    if (pred_correct !== e.correct) begin
      errors++;
      $display("[TB] FAIL pred_correct: got %b, required %b", pred_correct, e.correct);
    end
    held     = output_error;
    held_cls = pred_class;
    held_ok  = pred_correct;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      for (int k = 0; k < OUTPUT_DIM; k++) fcl_output[k] = 16'sd1234;
      label = 5'd2;
      tick();
      diffs = 0;
      for (int k = 0; k < OUTPUT_DIM; k++) if (output_error[k] !== held[k]) diffs++;
      checks++;
      if (diffs != 0 || pred_class !== held_cls || pred_correct !== held_ok) begin
        errors++;
        $display("[TB] FAIL stall_hold: %0d elements changed, pred %0d/%b, required %0d/%b",
                 diffs, pred_class, pred_correct, held_cls, held_ok);
      end
      checks++;
      if (in_ready !== 1'b0 || err_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_flags: in_ready=%b err_valid=%b, required 0/1", in_ready, err_valid);
      end
    end
    in_valid  = 1'b0;
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    if (e.correct && exp_count != {CNT_W{1'b1}}) exp_count = exp_count + 1'b1;
    checks++;
    if (err_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake: err_valid=%b in_ready=%b, required 0/1", err_valid, in_ready);
    end
    checks++;
    if (correct_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL correct_count: got %0d, required %0d", correct_count, exp_count);
    end
    if (hold > 0) begin
      tick();
      checks++;
      if (err_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pulse_ignored: err_valid=%b in_ready=%b, required 0/1", err_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    int nz;
    reset = 1'b1;
    tick();
    tick();
    nz = 0;
    for (int k = 0; k < OUTPUT_DIM; k++) if (output_error[k] !== 16'sd0) nz++;
    checks++;
    if (in_ready !== 1'b1 || err_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: in_ready=%b err_valid=%b, required 1/0", in_ready, err_valid);
    end
    checks++;
    if (nz != 0 || pred_class !== 4'd0 || pred_correct !== 1'b0 || correct_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: %0d nonzero errs, pred %0d/%b count %0d, required 0,0/0,0",
               nz, pred_class, pred_correct, correct_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'sd16;
    stim_x[3] = 16'sd400;
    applyStimulus(5'd3);
    checkOutput(0);
    checks++;
    if (output_error[3] !== 16'sd144 || output_error[0] !== 16'sd16 || output_error[9] !== 16'sd16) begin
      errors++;
      $display("[TB] FAIL basic_const: err[3]=%0d err[0]=%0d err[9]=%0d, required 144/16/16",
               output_error[3], output_error[0], output_error[9]);
    end
    checks++;
    if (pred_class !== 4'd3 || correct_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL basic_pred: class %0d count %0d, required 3/1", pred_class, correct_count);
    end
  endtask

  task automatic test_tie();
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = -16'sd50;
    stim_x[1] = 16'sd100;
    stim_x[5] = 16'sd100;
    applyStimulus(5'd5);
    checkOutput(0);
    checks++;
    if (output_error[5] !== -16'sd156 || output_error[1] !== 16'sd100 || pred_class !== 4'd1
        || pred_correct !== 1'b0 || correct_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL tie_const: err5=%0d err1=%0d class %0d ok %b count %0d, required -156/100/1/0/1",
               output_error[5], output_error[1], pred_class, pred_correct, correct_count);
    end
  endtask

  task automatic test_saturation();
    logic signed [WIDTH-1:0] want;
`ifdef FCL_LOSS_SAT_EN
    want = -16'sd32768;
`else
    want = 16'sd32512;
`endif
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'sd0;
    stim_x[0] = -16'sd32768;
    applyStimulus(5'd0);
    checkOutput(0);
    checks++;
    if (output_error[0] !== want) begin
      errors++;
      $display("[TB] FAIL sat_err0: got %0d, required %0d", output_error[0], want);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'(k * 7 - 20);
    stim_x[6] = 16'sd300;
    applyStimulus(5'd6);
    checkOutput(5);
  endtask

  task automatic test_reset_mid_scan();
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'sd40;
    applyStimulus(5'd0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_count = '0;
    checks++;
    if (in_ready !== 1'b1 || err_valid !== 1'b0 || correct_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL mid_scan_reset: in_ready=%b err_valid=%b count %0d, required 1/0/0",
               in_ready, err_valid, correct_count);
    end
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'sd16;
    stim_x[3] = 16'sd400;
    applyStimulus(5'd3);
    checkOutput(0);
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'(k * 10);
    applyStimulus(5'd12);
    checkOutput(0);
    checks++;
    if (output_error[7] !== 16'sd70 || pred_class !== 4'd9 || pred_correct !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_const: err7=%0d class %0d ok %b, required 70/9/0",
               output_error[7], pred_class, pred_correct);
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    logic [LBL_W-1:0] lbl;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      lbl = LBL_W'($urandom_range(0, 15));
      for (int k = 0; k < OUTPUT_DIM; k++) stim_x[k] = 16'($urandom);
      if (i % 2 == 0 && lbl < 5'd10) stim_x[lbl] = 16'sd32000;
      applyStimulus(lbl);
      if (i > 0) begin
        checks++;
        if (last_accept - prev != PERIOD) begin
          errors++;
          $display("[TB] FAIL throughput: %0d cycles between accepts, required %0d",
                   last_accept - prev, PERIOD);
        end
      end
      prev = last_accept;
      checkOutput(0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    err_ready = 1'b0;
    label     = '0;
    for (int k = 0; k < OUTPUT_DIM; k++) fcl_output[k] = '0;
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_backpressure();
    test_reset_mid_scan();
    test_out_of_range();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
